fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 152 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO onto an asynchronous serial line, LSB first (8-N-1).
// Define TX_PARITY_EN to append an even-parity bit after the data bits (8-E-1).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifoData,
  input  logic       fifoEmpty,
  output logic       fifoRe,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic        tx_nxt, busy_nxt, done_nxt, re_nxt;
  logic        load, shift_en, bit_end;
  logic [7:0]  shift_reg;
`ifdef TX_PARITY_EN
  logic        parity;
`endif

  // tx is registered, so each transition presets the level of the bit being entered
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    tx_nxt    = tx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    re_nxt    = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    bit_end   = (baud_cnt == BAUD_LAST);
    if (state != IDLE) begin
      baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
    end
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        baud_nxt = 16'd0;
        bit_nxt  = 3'd0;
        if (!fifoEmpty) begin
          load      = 1'b1;
          re_nxt    = 1'b1;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt  = bit_cnt + 3'd1;
            shift_en = 1'b1;
            tx_nxt   = shift_reg[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      fifoRe   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      fifoRe   <= re_nxt;
    end
  end

  // Byte datapath: no reset, contents only matter once a frame has been loaded
  always_ff @(posedge clk) begin
    if (load) begin
      shift_reg <= fifoData;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

`ifdef TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (load) begin
      parity <= ^fifoData;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 and 2 clocks per bit) fed from queue FIFOs, checked
// every cycle against a frame-timeline model plus hand-computed frame literals.
module tb_fifo_uart_tx;
`ifdef TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  typedef struct packed {
    logic        active;
    int          t;
    logic [10:0] frame;
    logic        tx;
    logic        busy;
    logic        done;
    logic        re;
  } model_t;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] data4  = 8'h00;
  logic [7:0] data2  = 8'h00;
  logic       empty4 = 1'b1;
  logic       empty2 = 1'b1;
  logic       re4, tx4, busy4, done4;
  logic       re2, tx2, busy2, done2;
  logic [7:0] q4[$];
  logic [7:0] q2[$];
  logic [7:0] cap2[$];
  logic [7:0] sent2[$];
  logic [7:0] got2[$];
  model_t     m4 = '0;
  model_t     m2 = '0;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         re_cnt4 = 0;
  int         re_cnt2 = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .fifoData(data4), .fifoEmpty(empty4),
    .fifoRe(re4), .tx(tx4), .busy(busy4), .done(done4)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .fifoData(data2), .fifoEmpty(empty2),
    .fifoRe(re2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // A frame is a fixed bit vector replayed at n clocks per bit; it ends with one idle cycle carrying done
  function automatic model_t model_step(input model_t m, input logic rst, input logic empty,
                                        input logic [7:0] d, input int n);
    model_t r;
    r      = m;
    r.done = 1'b0;
    r.re   = 1'b0;
    if (rst) begin
      r.active = 1'b0;
      r.tx     = 1'b1;
      r.busy   = 1'b0;
    end else if (m.active) begin
      r.t = m.t + 1;
      if (r.t == FBITS * n) begin
        r.active = 1'b0;
        r.tx     = 1'b1;
        r.busy   = 1'b0;
        r.done   = 1'b1;
      end else begin
        r.tx = r.frame[r.t / n];
      end
    end else if (!empty) begin
      r.active = 1'b1;
      r.t      = 0;
      r.re     = 1'b1;
      r.tx     = 1'b0;
      r.busy   = 1'b1;
`ifdef TX_PARITY_EN
      r.frame  = {1'b1, ^d, d, 1'b0};
`else
      r.frame  = {2'b11, d, 1'b0};
`endif
    end else begin
      r.tx   = 1'b1;
      r.busy = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m4 = model_step(m4, reset, empty4, data4, 4);
    m2 = model_step(m2, reset, empty2, data2, 2);
    if (m2.re) cap2.push_back(data2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut4_tx_busy_done_re", {28'd0, tx4, busy4, done4, re4},
            {28'd0, m4.tx, m4.busy, m4.done, m4.re});
      check("dut2_tx_busy_done_re", {28'd0, tx2, busy2, done2, re2},
            {28'd0, m2.tx, m2.busy, m2.done, m2.re});
    end
    if (re4 === 1'b1) begin
      re_cnt4++;
      if (q4.size() > 0) void'(q4.pop_front());
    end
    if (re2 === 1'b1) begin
      re_cnt2++;
      if (q2.size() > 0) void'(q2.pop_front());
    end
    empty4 = (q4.size() == 0);
    data4  = empty4 ? 8'h00 : q4[0];
    empty2 = (q2.size() == 0);
    data2  = empty2 ? 8'h00 : q2[0];
  end

  function automatic logic tx_of(input bit sel);
    return sel ? tx2 : tx4;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done2 : done4;
  endfunction

  // Waits (bounded) for a start bit, then samples one level per bit and done at frame end
  task automatic recv(input bit sel, input int limit, output int waited,
                      output logic [10:0] bits, output logic done_ok);
    int n;
    n       = sel ? 2 : 4;
    waited  = 0;
    bits    = '1;
    done_ok = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_of(sel) !== 1'b0 && waited < limit);
    if (tx_of(sel) !== 1'b0) begin
      waited = -1;
      return;
    end
    for (int c = 1; c <= FBITS * n; c++) begin
      @(negedge clk);
      if (c % n == 1) bits[c / n] = tx_of(sel);
      if (c == FBITS * n) done_ok = done_of(sel);
    end
  endtask

  initial begin
    int          w;
    int          r0;
    int          bad;
    logic [10:0] b;
    logic        d;
    logic [7:0]  exp3[3];

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_tx", tx4, 1);
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_fifore", re4, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single byte 0x55
    r0 = re_cnt4;
    @(posedge clk);
    #1;
    q4.push_back(8'h55);
    recv(1'b0, 20, w, b, d);
    check("b55_latency", w, 2);
`ifdef TX_PARITY_EN
    check("b55_levels", b, 11'h4AA);
`else
    check("b55_levels", b, 11'h6AA);
`endif
    check("b55_done_at_frame_end", d, 1);
    check("b55_fifore_pulses", re_cnt4 - r0, 1);

    // back-to-back frames
    exp3[0] = 8'hA3;
    exp3[1] = 8'h00;
    exp3[2] = 8'hFF;
    r0 = re_cnt4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) q4.push_back(exp3[i]);
    for (int i = 0; i < 3; i++) begin
      recv(1'b0, 20, w, b, d);
      check("b2b_gap", w, (i == 0) ? 2 : 1);
      check("b2b_data", b[8:1], exp3[i]);
      check("b2b_stop", b[FBITS-1], 1);
      check("b2b_done", d, 1);
    end
    check("b2b_fifore_pulses", re_cnt4 - r0, 3);

    // empty FIFO keeps the line quiet
    bad = 0;
    r0  = re_cnt4;
    repeat (200) begin
      @(negedge clk);
      if (re4 !== 1'b0 || tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) bad++;
    end
    check("idle_quiet_cycles", bad, 0);
    check("idle_no_fifore", re_cnt4 - r0, 0);

    // reset during data bit 3 of 0x0F
    @(posedge clk);
    #1;
    q4.push_back(8'h0F);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx4 !== 1'b0 && w < 20);
    check("rst_frame_start", w, 2);
    repeat (17) @(negedge clk);
    check("rst_bit3_level", tx4, 1);
    check("rst_busy_in_frame", busy4, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q4.push_back(8'h81);
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_high", tx4, 1);
    check("rst_busy_low", busy4, 0);
    check("rst_no_done", done4, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    recv(1'b0, 20, w, b, d);
    check("after_rst_latency", w, 2);
    check("after_rst_data", b[8:1], 8'h81);
    check("after_rst_done", d, 1);

`ifdef TX_PARITY_EN
    // parity bit of 0x07 is 1, of 0x03 is 0
    @(posedge clk);
    #1;
    q4.push_back(8'h07);
    q4.push_back(8'h03);
    recv(1'b0, 20, w, b, d);
    check("par07_data", b[8:1], 8'h07);
    check("par07_parity", b[9], 1);
    check("par07_done_at_44", d, 1);
    recv(1'b0, 20, w, b, d);
    check("par03_gap", w, 1);
    check("par03_data", b[8:1], 8'h03);
    check("par03_parity", b[9], 0);
    check("par03_stop", b[10], 1);
`endif

    // minimum bit period, streamed bytes with upstream writes interleaved
    r0 = re_cnt2;
    fork
      begin
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
          v = 8'($urandom);
          sent2.push_back(v);
          @(posedge clk);
          #1;
          q2.push_back(v);
          repeat ($urandom_range(0, 30)) @(posedge clk);
        end
      end
      begin
        int          w2;
        logic [10:0] b2;
        logic        d2;
        for (int i = 0; i < 16; i++) begin
          recv(1'b1, 300, w2, b2, d2);
          check("fast_frame_seen", {31'd0, w2 > 0}, 1);
          check("fast_done", d2, 1);
          got2.push_back(b2[8:1]);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("fast_fifore_pulses", re_cnt2 - r0, 16);
    check("fast_capture_count", cap2.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check("fast_rx_order", got2[i], sent2[i]);
      if (i < cap2.size()) check("fast_capture_order", cap2[i], sent2[i]);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
